// File: rtl/pktunit_axis_arb.sv
// pktunit_axis_arb
// Round-robin packet arbiter merging NUM_IN pktunit streams onto one output.
// Each stream has three sub-channels (flags, data, eop) with their own
// valid/ready. One flags word is forwarded per packet, then data+eop beats
// move together until a beat with a non-zero eop mask. The grant is held for
// the whole packet, so packets never interleave.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_data_d/v/r                per-input data beats (slice i = DATA_BYTES*8 bits)
//   in_flags_d/v/r               per-input packet flags (slice i = 8 bits)
//   in_eop_d/v/r                 per-input byte-end mask (slice i = DATA_BYTES bits)
//   out_data_*, out_flags_*, out_eop_*   merged output stream
//   grant                        current / most recently granted input
//   busy                         high while a packet is being forwarded
//
// Optional build macro PKTUNIT_ARB_STATS_EN adds:
//   pkt_cnt  [NUM_IN*32]         per-input completed packet counters
//   beat_cnt [32]                total beat transfers
module pktunit_axis_arb #(
  parameter int NUM_IN = 2,
  parameter int DATA_BYTES = 8,
  localparam int GW = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_BYTES*8-1:0] in_data_d,
  input  logic [NUM_IN-1:0]            in_data_v,
  output logic [NUM_IN-1:0]            in_data_r,
  input  logic [NUM_IN*8-1:0]          in_flags_d,
  input  logic [NUM_IN-1:0]            in_flags_v,
  output logic [NUM_IN-1:0]            in_flags_r,
  input  logic [NUM_IN*DATA_BYTES-1:0] in_eop_d,
  input  logic [NUM_IN-1:0]            in_eop_v,
  output logic [NUM_IN-1:0]            in_eop_r,
  output logic [DATA_BYTES*8-1:0]      out_data_d,
  output logic                         out_data_v,
  input  logic                         out_data_r,
  output logic [7:0]                   out_flags_d,
  output logic                         out_flags_v,
  input  logic                         out_flags_r,
  output logic [DATA_BYTES-1:0]        out_eop_d,
  output logic                         out_eop_v,
  input  logic                         out_eop_r,
  output logic [GW-1:0]                grant,
  output logic                         busy
`ifdef PKTUNIT_ARB_STATS_EN
  ,
  output logic [NUM_IN*32-1:0]         pkt_cnt,
  output logic [31:0]                  beat_cnt
`endif
);

  localparam int DW = DATA_BYTES * 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLAGS = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_ptr_q;
  logic            busy_q;

  logic [GW-1:0]   pick_s;
  logic            pair_v_s;
  logic            beat_xfer_s;
  logic            last_beat_s;

  // (base + step) mod NUM_IN; step is always < NUM_IN so one subtraction suffices
  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_IN) begin
      sum = sum - NUM_IN;
    end
    return sum[GW-1:0];
  endfunction

  // Round-robin pick: scan downwards so the entry closest to rr_ptr is assigned last and wins
  always_comb begin
    pick_s = rr_ptr_q;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      pick_s = in_flags_v[next_idx(rr_ptr_q, k)] ? next_idx(rr_ptr_q, k) : pick_s;
    end
  end

  // Datapath mux and handshake steering, driven purely from the registered grant
  always_comb begin
    out_data_d  = in_data_d[int'(grant_q)*DW +: DW];
    out_flags_d = in_flags_d[int'(grant_q)*8 +: 8];
    out_eop_d   = in_eop_d[int'(grant_q)*DATA_BYTES +: DATA_BYTES];
    pair_v_s    = in_data_v[grant_q] & in_eop_v[grant_q];
    out_data_v  = 1'b0;
    out_flags_v = 1'b0;
    out_eop_v   = 1'b0;
    in_data_r   = {NUM_IN{1'b0}};
    in_flags_r  = {NUM_IN{1'b0}};
    in_eop_r    = {NUM_IN{1'b0}};
    case (state_q)
      S_IDLE: begin
        out_flags_v = 1'b0;
      end
      S_FLAGS: begin
        out_flags_v         = in_flags_v[grant_q];
        in_flags_r[grant_q] = out_flags_r;
      end
      S_DATA: begin
        out_data_v = pair_v_s;
        out_eop_v  = pair_v_s;
        // input ready only when the whole beat moves, so data and eop stay aligned
        in_data_r[grant_q] = out_data_r & out_eop_r & pair_v_s;
        in_eop_r[grant_q]  = out_data_r & out_eop_r & pair_v_s;
      end
      default: begin
        out_flags_v = 1'b0;
      end
    endcase
  end

  assign beat_xfer_s = (state_q == S_DATA) & out_data_v & out_eop_v & out_data_r & out_eop_r;
  assign last_beat_s = beat_xfer_s & (|out_eop_d);

  // Packet-level FSM: arbitrate in IDLE, forward flags, then beats until the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= {GW{1'b0}};
      rr_ptr_q <= {GW{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|in_flags_v) begin
            grant_q <= pick_s;
            state_q <= S_FLAGS;
            busy_q  <= 1'b1;
          end
        end
        S_FLAGS: begin
          if (out_flags_v & out_flags_r) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (last_beat_s) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= next_idx(grant_q, 1);
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

`ifdef PKTUNIT_ARB_STATS_EN
  logic [NUM_IN*32-1:0] pkt_cnt_q;
  logic [31:0]          beat_cnt_q;

  // Statistics counters; both wrap naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= {(NUM_IN*32){1'b0}};
      beat_cnt_q <= 32'd0;
    end else begin
      if (beat_xfer_s) begin
        beat_cnt_q <= beat_cnt_q + 32'd1;
      end
      if (last_beat_s) begin
        pkt_cnt_q[int'(grant_q)*32 +: 32] <= pkt_cnt_q[int'(grant_q)*32 +: 32] + 32'd1;
      end
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_pktunit_axis_arb.sv
// Directed bench for pktunit_axis_arb: a 2-input instance (u_a) for most
// scenarios and a 4-input instance (u_b) for pointer wrap-around.
module tb_pktunit_axis_arb;

  typedef logic [31:0] rec_t;

  logic clk;
  logic rst;

  // ---------------- 2-input instance ----------------
  logic [127:0] a_in_data_d;
  logic [1:0]   a_in_data_v, a_in_data_r;
  logic [15:0]  a_in_flags_d;
  logic [1:0]   a_in_flags_v, a_in_flags_r;
  logic [15:0]  a_in_eop_d;
  logic [1:0]   a_in_eop_v, a_in_eop_r;
  logic [63:0]  a_out_data_d;
  logic         a_out_data_v, a_out_data_r;
  logic [7:0]   a_out_flags_d;
  logic         a_out_flags_v, a_out_flags_r;
  logic [7:0]   a_out_eop_d;
  logic         a_out_eop_v, a_out_eop_r;
  logic         a_grant;
  logic         a_busy;
`ifdef PKTUNIT_ARB_STATS_EN
  logic [63:0]  a_pkt_cnt;
  logic [31:0]  a_beat_cnt;
`endif

  // ---------------- 4-input instance ----------------
  logic [255:0] b_in_data_d;
  logic [3:0]   b_in_data_v, b_in_data_r;
  logic [31:0]  b_in_flags_d;
  logic [3:0]   b_in_flags_v, b_in_flags_r;
  logic [31:0]  b_in_eop_d;
  logic [3:0]   b_in_eop_v, b_in_eop_r;
  logic [63:0]  b_out_data_d;
  logic         b_out_data_v, b_out_data_r;
  logic [7:0]   b_out_flags_d;
  logic         b_out_flags_v, b_out_flags_r;
  logic [7:0]   b_out_eop_d;
  logic         b_out_eop_v, b_out_eop_r;
  logic [1:0]   b_grant;
  logic         b_busy;
`ifdef PKTUNIT_ARB_STATS_EN
  logic [127:0] b_pkt_cnt;
  logic [31:0]  b_beat_cnt;
`endif

  int   total_cnt;
  int   bad_cnt;
  logic bp_on;
  rec_t a_fq[$];
  rec_t a_bq[$];
  rec_t b_fq[$];
  rec_t b_bq[$];
  rec_t exp_f[$];
  rec_t exp_b[$];

  pktunit_axis_arb #(.NUM_IN(2), .DATA_BYTES(8)) u_a (
    .clk(clk), .rst(rst),
    .in_data_d(a_in_data_d), .in_data_v(a_in_data_v), .in_data_r(a_in_data_r),
    .in_flags_d(a_in_flags_d), .in_flags_v(a_in_flags_v), .in_flags_r(a_in_flags_r),
    .in_eop_d(a_in_eop_d), .in_eop_v(a_in_eop_v), .in_eop_r(a_in_eop_r),
    .out_data_d(a_out_data_d), .out_data_v(a_out_data_v), .out_data_r(a_out_data_r),
    .out_flags_d(a_out_flags_d), .out_flags_v(a_out_flags_v), .out_flags_r(a_out_flags_r),
    .out_eop_d(a_out_eop_d), .out_eop_v(a_out_eop_v), .out_eop_r(a_out_eop_r),
    .grant(a_grant), .busy(a_busy)
`ifdef PKTUNIT_ARB_STATS_EN
    , .pkt_cnt(a_pkt_cnt), .beat_cnt(a_beat_cnt)
`endif
  );

  pktunit_axis_arb #(.NUM_IN(4), .DATA_BYTES(8)) u_b (
    .clk(clk), .rst(rst),
    .in_data_d(b_in_data_d), .in_data_v(b_in_data_v), .in_data_r(b_in_data_r),
    .in_flags_d(b_in_flags_d), .in_flags_v(b_in_flags_v), .in_flags_r(b_in_flags_r),
    .in_eop_d(b_in_eop_d), .in_eop_v(b_in_eop_v), .in_eop_r(b_in_eop_r),
    .out_data_d(b_out_data_d), .out_data_v(b_out_data_v), .out_data_r(b_out_data_r),
    .out_flags_d(b_out_flags_d), .out_flags_v(b_out_flags_v), .out_flags_r(b_out_flags_r),
    .out_eop_d(b_out_eop_d), .out_eop_v(b_out_eop_v), .out_eop_r(b_out_eop_r),
    .grant(b_grant), .busy(b_busy)
`ifdef PKTUNIT_ARB_STATS_EN
    , .pkt_cnt(b_pkt_cnt), .beat_cnt(b_beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitors: record every flags word (with grant) and every beat at mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_flags_v && a_out_flags_r)
        a_fq.push_back({23'h0, a_grant, a_out_flags_d});
      if (a_out_data_v && a_out_eop_v && a_out_data_r && a_out_eop_r)
        a_bq.push_back({8'h00, a_out_data_d[63:56], a_out_data_d[7:0], a_out_eop_d});
      if (b_out_flags_v && b_out_flags_r)
        b_fq.push_back({22'h0, b_grant, b_out_flags_d});
      if (b_out_data_v && b_out_eop_v && b_out_data_r && b_out_eop_r)
        b_bq.push_back({8'h00, b_out_data_d[63:56], b_out_data_d[7:0], b_out_eop_d});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input rec_t got[$], input rec_t exp[$]);
    chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk(tag, 64'(got[i]), 64'(exp[i]));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Source model on the 2-input instance: flags, then beats 0..stop-1 of an nb-beat packet.
  // Beat b carries {f, 48'h0, b}; the final beat of the packet has eop 0x0F.
  task automatic send_a(input int i, input logic [7:0] f, input int nb, input int stop);
    int   n;
    logic hs;
    a_in_flags_d[i*8 +: 8] = f;
    a_in_flags_v[i] = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk); hs = a_in_flags_r[i];
      @(posedge clk); #1; n++;
    end
    if (!hs) chk("a_flags_timeout", 64'd0, 64'd1);
    a_in_flags_v[i] = 1'b0;
    for (int b = 0; b < stop; b++) begin
      a_in_data_d[i*64 +: 64] = {f, 48'h0, 8'(b)};
      a_in_eop_d[i*8 +: 8] = (b == nb - 1) ? 8'h0F : 8'h00;
      a_in_data_v[i] = 1'b1;
      a_in_eop_v[i] = 1'b1;
      n = 0; hs = 1'b0;
      while (!hs && n < 100) begin
        @(negedge clk); hs = a_in_data_r[i];
        @(posedge clk); #1; n++;
      end
      if (!hs) chk("a_beat_timeout", 64'd0, 64'd1);
      a_in_data_v[i] = 1'b0;
      a_in_eop_v[i] = 1'b0;
    end
  endtask

  // Single-beat packet source on the 4-input instance
  task automatic send_b(input int i, input logic [7:0] f);
    int   n;
    logic hs;
    b_in_flags_d[i*8 +: 8] = f;
    b_in_flags_v[i] = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk); hs = b_in_flags_r[i];
      @(posedge clk); #1; n++;
    end
    if (!hs) chk("b_flags_timeout", 64'd0, 64'd1);
    b_in_flags_v[i] = 1'b0;
    b_in_data_d[i*64 +: 64] = {f, 56'h0};
    b_in_eop_d[i*8 +: 8] = 8'h0F;
    b_in_data_v[i] = 1'b1;
    b_in_eop_v[i] = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk); hs = b_in_data_r[i];
      @(posedge clk); #1; n++;
    end
    if (!hs) chk("b_beat_timeout", 64'd0, 64'd1);
    b_in_data_v[i] = 1'b0;
    b_in_eop_v[i] = 1'b0;
  endtask

  initial begin
    total_cnt = 0; bad_cnt = 0; bp_on = 1'b0;
    rst = 1'b1;
    a_in_data_d = '0; a_in_data_v = '0; a_in_flags_d = '0; a_in_flags_v = '0;
    a_in_eop_d = '0; a_in_eop_v = '0;
    a_out_data_r = 1'b1; a_out_flags_r = 1'b1; a_out_eop_r = 1'b1;
    b_in_data_d = '0; b_in_data_v = '0; b_in_flags_d = '0; b_in_flags_v = '0;
    b_in_eop_d = '0; b_in_eop_v = '0;
    b_out_data_r = 1'b1; b_out_flags_r = 1'b1; b_out_eop_r = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- reset state: data pending on both inputs must not leak through ----
    a_in_data_d = {64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF};
    a_in_data_v = 2'b11; a_in_eop_v = 2'b11;
    #1;
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_grant", 64'(a_grant), 64'd0);
    chk("rst_out_v", 64'({a_out_data_v, a_out_flags_v, a_out_eop_v}), 64'd0);
    chk("rst_in_r", 64'({a_in_data_r, a_in_flags_r, a_in_eop_r}), 64'd0);
    chk("rst_slice0", a_out_data_d, 64'h0123_4567_89AB_CDEF);
    chk("rst_b_busy_grant", 64'({b_busy, b_grant}), 64'd0);
    a_in_data_v = 2'b00; a_in_eop_v = 2'b00;

    // ---- single source, 3 beats ----
    a_fq.delete(); a_bq.delete();
    send_a(0, 8'hA5, 3, 3);
    chk("t1_idle_after", 64'(a_busy), 64'd0);
    chk("t1_rr_ptr", 64'(u_a.rr_ptr_q), 64'd1);
    exp_f = '{32'h0000_00A5};
    exp_b = '{32'h00A5_0000, 32'h00A5_0100, 32'h00A5_020F};
    cmp_q("t1_flags", a_fq, exp_f);
    cmp_q("t1_beats", a_bq, exp_b);

    // ---- round-robin with both inputs always requesting ----
    pulse_reset();
    a_fq.delete(); a_bq.delete();
    fork
      begin send_a(0, 8'h10, 2, 2); send_a(0, 8'h11, 2, 2); end
      begin send_a(1, 8'h20, 2, 2); send_a(1, 8'h21, 2, 2); end
    join
    exp_f = '{32'h0000_0010, 32'h0000_0120, 32'h0000_0011, 32'h0000_0121};
    exp_b = '{32'h0010_0000, 32'h0010_010F, 32'h0020_0000, 32'h0020_010F,
              32'h0011_0000, 32'h0011_010F, 32'h0021_0000, 32'h0021_010F};
    cmp_q("t2_flags", a_fq, exp_f);
    cmp_q("t2_beats", a_bq, exp_b);

    // ---- backpressure on input 1, input 0 holds stray data valid ----
    a_fq.delete(); a_bq.delete();
    a_in_data_d[63:0] = 64'hDEAD_BEEF_DEAD_BEEF;
    a_in_data_v[0] = 1'b1; a_in_eop_v[0] = 1'b1;
    bp_on = 1'b1;
    fork
      begin send_a(1, 8'h30, 4, 4); bp_on = 1'b0; end
      begin
        int k;
        k = 0;
        while (bp_on) begin
          @(posedge clk); #1;
          a_out_data_r = (k % 4 == 0) || (k % 4 == 3);
          k++;
        end
      end
      begin
        while (bp_on) begin
          @(negedge clk);
          if (bp_on) begin
            chk("t3_in0_rdy", 64'(a_in_data_r[0]), 64'd0);
            if (a_out_data_v) chk("t3_in1_rdy", 64'(a_in_data_r[1]), 64'(a_out_data_r));
          end
        end
      end
    join
    a_out_data_r = 1'b1;
    a_in_data_v[0] = 1'b0; a_in_eop_v[0] = 1'b0;
    exp_f = '{32'h0000_0130};
    exp_b = '{32'h0030_0000, 32'h0030_0100, 32'h0030_0200, 32'h0030_030F};
    cmp_q("t3_flags", a_fq, exp_f);
    cmp_q("t3_beats", a_bq, exp_b);

    // ---- wrap and skip on the 4-input instance ----
    b_fq.delete(); b_bq.delete();
    send_b(2, 8'h52);
    chk("t4_rr_ptr", 64'(u_b.rr_ptr_q), 64'd3);
    b_fq.delete(); b_bq.delete();
    fork
      send_b(1, 8'h61);
      send_b(2, 8'h62);
    join
    exp_f = '{32'h0000_0161, 32'h0000_0262};
    exp_b = '{32'h0061_000F, 32'h0062_000F};
    cmp_q("t4_flags", b_fq, exp_f);
    cmp_q("t4_beats", b_bq, exp_b);

    // ---- reset in the middle of a 5-beat packet from input 1 ----
    a_fq.delete(); a_bq.delete();
    send_a(1, 8'h40, 5, 2);
    chk("t5_grant_before", 64'(a_grant), 64'd1);
    pulse_reset();
    a_in_data_v = 2'b11; a_in_eop_v = 2'b11;
    #1;
    chk("t5_busy", 64'(a_busy), 64'd0);
    chk("t5_grant", 64'(a_grant), 64'd0);
    chk("t5_out_v", 64'({a_out_data_v, a_out_flags_v, a_out_eop_v}), 64'd0);
    chk("t5_in_r", 64'({a_in_data_r, a_in_flags_r, a_in_eop_r}), 64'd0);
    a_in_data_v = 2'b00; a_in_eop_v = 2'b00;
    exp_f = '{32'h0000_0140};
    exp_b = '{32'h0040_0000, 32'h0040_0100};
    cmp_q("t5_abandoned_flags", a_fq, exp_f);
    cmp_q("t5_abandoned_beats", a_bq, exp_b);
    a_fq.delete(); a_bq.delete();
    send_a(1, 8'h41, 2, 2);
    exp_f = '{32'h0000_0141};
    exp_b = '{32'h0041_0000, 32'h0041_010F};
    cmp_q("t5_new_flags", a_fq, exp_f);
    cmp_q("t5_new_beats", a_bq, exp_b);

`ifdef PKTUNIT_ARB_STATS_EN
    // ---- statistics: 3 packets on input 0, 2 on input 1, 10 beats ----
    pulse_reset();
    send_a(0, 8'h70, 2, 2);
    send_a(1, 8'h80, 2, 2);
    send_a(0, 8'h71, 2, 2);
    send_a(1, 8'h81, 2, 2);
    send_a(0, 8'h72, 2, 2);
    chk("t6_pkt_cnt", a_pkt_cnt, {32'd2, 32'd3});
    chk("t6_beat_cnt", 64'(a_beat_cnt), 64'd10);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
